// File: rtl/controller_uart1_tx_pkg.sv
// ============================================================================
// Module      : controller_uart1_tx_pkg
// Description : Shared types and constants for the uart1 transmitter:
//               serializer state encoding, register addresses, STATUS bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package controller_uart1_tx_pkg;

  // Serializer states; two bits cover all four.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Avalon word addresses
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;

  // STATUS register bit positions
  localparam int STAT_BUSY  = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_OVF   = 3;

endpackage

`default_nettype wire

// File: rtl/controller_uart1_tx_fifo.sv
// ============================================================================
// Module      : controller_uart1_tx_fifo
// Description : Synchronous byte FIFO holding 2**COUNT_W-1 entries. Occupancy
//               is tracked by an explicit counter; full/empty come from it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module controller_uart1_tx_fifo #(
  parameter int COUNT_W = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               push,
  input  logic [7:0]         din,
  input  logic               pop,
  output logic [7:0]         dout,
  output logic [COUNT_W-1:0] count,
  output logic               full,
  output logic               empty,
  output logic               push_ok
);

  localparam int                 SLOTS     = 2 ** COUNT_W;
  localparam logic [COUNT_W-1:0] MAX_COUNT = COUNT_W'(SLOTS - 1);

  logic [7:0]         mem_q [SLOTS];
  logic [7:0]         mem_d [SLOTS];
  logic [COUNT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [COUNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               pop_ok;

  assign full  = (count_q == MAX_COUNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;

  // Next pointers, occupancy and storage contents.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

`default_nettype wire

// File: rtl/controller_uart1_tx.sv
// ============================================================================
// Module      : controller_uart1_tx
// Description : Avalon-MM slave 8N1 UART transmitter. Bytes written to DATA
//               are queued in a small FIFO and shifted out LSB first on txd.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module controller_uart1_tx
  import controller_uart1_tx_pkg::*;
#(
  parameter int CLK_DIV = 434,
  parameter int COUNT_W = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  output logic               txd,
  output logic [COUNT_W-1:0] tx_count,
  output logic               tx_busy
);

  localparam int                BAUD_W    = $clog2(CLK_DIV);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);

  tx_state_e         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              txd_q, txd_d;
  logic              overflow_q, overflow_d;
  logic [31:0]       readdata_q, readdata_d;

  logic              wr;
  logic              push;
  logic              clr_ovf;
  logic              pop;
  logic              baud_tick;
  logic [BAUD_W-1:0] baud_next;
  logic [7:0]        fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push_ok;
  logic [31:0]       status;
  logic              unused_wdata;

  assign wr        = chipselect & ~write_n;
  assign push      = wr & (address == ADDR_DATA);
  assign clr_ovf   = wr & (address == ADDR_STATUS);
  assign baud_tick = (baud_q == BAUD_LAST);
  assign baud_next = baud_tick ? '0 : baud_q + 1'b1;

  // Only the low byte of a DATA write is meaningful.
  assign unused_wdata = ^writedata[31:8];

  controller_uart1_tx_fifo #(
    .COUNT_W (COUNT_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .din     (writedata[7:0]),
    .pop     (pop),
    .dout    (fifo_dout),
    .count   (tx_count),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .push_ok (push_ok)
  );

  // Serializer next-state: frame sequencing, baud timing, FIFO pop, txd level.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    txd_d     = 1'b1;
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          state_d = ST_START;
        end
      end
      ST_START: begin
        txd_d  = 1'b0;
        baud_d = baud_next;
        if (baud_tick) begin
          bit_idx_d = 3'd0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        txd_d  = shift_q[bit_idx_q];
        baud_d = baud_next;
        if (baud_tick) begin
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      ST_STOP: begin
        txd_d  = 1'b1;
        baud_d = baud_next;
        if (baud_tick) begin
          // Chain straight into the next frame so queued bytes leave gap-free.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sticky overflow on a dropped push; a STATUS write clears it and wins a tie.
  always_comb begin
    overflow_d = overflow_q;
    if (push && !push_ok) begin
      overflow_d = 1'b1;
    end
    if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  // Read mux, registered every cycle from the current address.
  always_comb begin
    status             = '0;
    status[STAT_BUSY]  = tx_busy;
    status[STAT_FULL]  = fifo_full;
    status[STAT_EMPTY] = fifo_empty;
    status[STAT_OVF]   = overflow_q;
    case (address)
      ADDR_DATA:   readdata_d = 32'(tx_count);
      ADDR_STATUS: readdata_d = status;
      default:     readdata_d = '0;
    endcase
  end

  // State, datapath and bus registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      overflow_q <= 1'b0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      overflow_q <= overflow_d;
      readdata_q <= readdata_d;
    end
  end

  assign tx_busy  = (state_q != ST_IDLE);
  assign txd      = txd_q;
  assign readdata = readdata_q;

endmodule

`default_nettype wire

// File: tb/tb_controller_uart1_tx.sv
// ============================================================================
// Module      : tb_controller_uart1_tx
// Description : Directed self-checking bench for controller_uart1_tx with
//               CLK_DIV=4. A free-running line receiver decodes txd frames.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_controller_uart1_tx;

  localparam int CLK_DIV = 4;
  localparam int COUNT_W = 3;
  localparam int FRAME   = 10 * CLK_DIV;

  logic               clk        = 1'b0;
  logic               reset_n    = 1'b0;
  logic [1:0]         address    = 2'd0;
  logic               chipselect = 1'b0;
  logic               write_n    = 1'b1;
  logic [31:0]        writedata  = 32'd0;
  logic [31:0]        readdata;
  logic               txd;
  logic [COUNT_W-1:0] tx_count;
  logic               tx_busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_q [$];
  int         rx_t [$];

  always #5 clk = ~clk;

  controller_uart1_tx #(
    .CLK_DIV (CLK_DIV),
    .COUNT_W (COUNT_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .txd        (txd),
    .tx_count   (tx_count),
    .tx_busy    (tx_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic do_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while (tx_busy && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", {31'd0, tx_busy}, 32'd0);
  endtask

  // Line receiver: finds the start edge, samples mid-bit, queues each byte.
  initial begin
    int         mon_cyc;
    int         mon_off;
    int         mon_start;
    logic       mon_act;
    logic [7:0] mon_sh;
    mon_cyc   = 0;
    mon_off   = 0;
    mon_start = 0;
    mon_act   = 1'b0;
    mon_sh    = 8'd0;
    forever begin
      @(posedge clk);
      #1;
      mon_cyc++;
      if (!reset_n) begin
        mon_act = 1'b0;
      end else if (!mon_act) begin
        if (txd === 1'b0) begin
          mon_act   = 1'b1;
          mon_off   = 0;
          mon_start = mon_cyc;
        end
      end else begin
        mon_off++;
        if (mon_off == CLK_DIV / 2) check("rx_start", {31'd0, txd}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          if (mon_off == CLK_DIV + CLK_DIV / 2 + CLK_DIV * i) mon_sh[i] = txd;
        end
        if (mon_off == 9 * CLK_DIV + CLK_DIV / 2) begin
          check("rx_stop", {31'd0, txd}, 32'd1);
          rx_q.push_back(mon_sh);
          rx_t.push_back(mon_start);
          mon_act = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [9:0]  frame;
    int          busy_cnt;

    // ---------------- reset ----------------
    reset_n = 1'b0;
    address = 2'd1;
    repeat (3) @(negedge clk);
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_count", 32'(tx_count), 32'd0);
    check("rst_readdata", readdata, 32'd0);
    check("rst_busy", {31'd0, tx_busy}, 32'd0);
    reset_n = 1'b1;
    do_read(2'd1, rd);
    check("rst_status", rd, 32'h4);
    do_read(2'd2, rd);
    check("addr2_read", rd, 32'h0);

    // ---------------- single byte ----------------
    do_write(2'd0, 32'hFFFF_FFA5);
    check("sb_count1", 32'(tx_count), 32'd1);
    check("sb_txd_pre", {31'd0, txd}, 32'd1);
    @(negedge clk);
    check("sb_count0", 32'(tx_count), 32'd0);
    check("sb_busy_on", {31'd0, tx_busy}, 32'd1);
    check("sb_txd_hold", {31'd0, txd}, 32'd1);
    busy_cnt = 1;
    frame    = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      check($sformatf("sb_txd_%0d", k), {31'd0, txd}, {31'd0, frame[k / CLK_DIV]});
      if (tx_busy) busy_cnt++;
    end
    check("sb_busy_len", busy_cnt, 32'd40);
    repeat (4) @(negedge clk);
    check("sb_rx_n", rx_q.size(), 32'd1);
    if (rx_q.size() > 0) check("sb_rx_byte", 32'(rx_q[0]), 32'hA5);
    rx_q.delete();
    rx_t.delete();

    // ---------------- burst and overflow ----------------
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      address    = 2'd0;
      writedata  = i;
      chipselect = 1'b1;
      write_n    = 1'b0;
    end
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    check("bu_count_peak", 32'(tx_count), 32'd7);
    do_read(2'd1, rd);
    check("bu_status_full", rd, 32'hB);
    do_read(2'd0, rd);
    check("bu_data_rd", rd, 32'd7);
    wait_idle(600);
    repeat (4) @(negedge clk);
    check("bu_rx_n", rx_q.size(), 32'd8);
    for (int i = 0; i < rx_q.size(); i++) begin
      check($sformatf("bu_rx_%0d", i), 32'(rx_q[i]), i + 1);
    end
    for (int i = 1; i < rx_t.size(); i++) begin
      check($sformatf("bu_gap_%0d", i), rx_t[i] - rx_t[i-1], FRAME);
    end
    if (rx_t.size() == 8) check("bu_span", rx_t[7] - rx_t[0] + FRAME, 32'd320);
    do_read(2'd1, rd);
    check("bu_status_sticky", rd, 32'hC);
    do_write(2'd1, 32'd0);
    do_read(2'd1, rd);
    check("bu_status_clr", rd, 32'h4);
    rx_q.delete();
    rx_t.delete();

    // ---------------- push and pop in the same cycle ----------------
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      address    = 2'd0;
      writedata  = 32'h11 + i;
      chipselect = 1'b1;
      write_n    = 1'b0;
    end
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    check("pp_count_full", 32'(tx_count), 32'd7);
    repeat (33) @(negedge clk);
    check("pp_count_pre", 32'(tx_count), 32'd7);
    address    = 2'd0;
    writedata  = 32'h19;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    check("pp_count_post", 32'(tx_count), 32'd7);
    do_read(2'd1, rd);
    check("pp_status", rd, 32'h3);
    wait_idle(600);
    repeat (4) @(negedge clk);
    check("pp_rx_n", rx_q.size(), 32'd9);
    for (int i = 0; i < rx_q.size(); i++) begin
      check($sformatf("pp_rx_%0d", i), 32'(rx_q[i]), 32'h11 + i);
    end
    rx_q.delete();
    rx_t.delete();

    // ---------------- reset mid-frame ----------------
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      address    = 2'd0;
      writedata  = (i == 0) ? 32'h35 : 32'h5A + i;
      chipselect = 1'b1;
      write_n    = 1'b0;
    end
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    check("rm_count_q", 32'(tx_count), 32'd2);
    repeat (16) @(negedge clk);
    check("rm_busy_pre", {31'd0, tx_busy}, 32'd1);
    check("rm_txd_bit3", {31'd0, txd}, 32'd0);
    reset_n = 1'b0;
    @(negedge clk);
    check("rm_txd", {31'd0, txd}, 32'd1);
    check("rm_count", 32'(tx_count), 32'd0);
    check("rm_busy", {31'd0, tx_busy}, 32'd0);
    reset_n = 1'b1;
    repeat (200) @(negedge clk);
    check("rm_rx_none", rx_q.size(), 32'd0);
    check("rm_txd_idle", {31'd0, txd}, 32'd1);
    check("rm_busy_idle", {31'd0, tx_busy}, 32'd0);
    check("rm_count_idle", 32'(tx_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
